gray_count_sampler: RTL and testbench

Downstream consumer of the Gray-code ripple counter tree: registers the counter's Gray word into the `clk_master` domain, converts it to binary, and on each `sample` strobe emits the number of counted events since the previous accepted sample over a valid/ready handshake. The block sits between the Gray counter tree and the readout/serialiser logic. It tolerates the counter bits changing asynchronously to `clk_master`, because only one Gray bit changes per count.

---
 rtl/gray_pkg.sv | 26 ++
 rtl/gray_count_sampler_if.sv | 11 +
 rtl/gray_sync.sv | 29 ++
 rtl/gray_count_sampler.sv | 98 +++++++++
 tb/tb_gray_count_sampler.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared constants and Gray/binary conversion helpers for the Gray counter readout path.
package gray_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int GRAY_MAX_W    = 32;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Callers zero-extend narrower words; leading zeros leave the prefix XOR unchanged.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_count_sampler_if.sv
// Valid/ready result channel from the sampler to the readout/serialiser logic.
interface gray_count_sampler_if #(
  parameter int WIDTH = gray_pkg::DEFAULT_WIDTH
);
  logic [WIDTH-1:0] out_delta;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_delta, output out_valid, input  out_ready);
  modport slave  (input  out_delta, input  out_valid, output out_ready);
endinterface

// File: rtl/gray_sync.sv
// Multi-stage synchroniser for the asynchronously changing Gray count word.
module gray_sync #(
  parameter int WIDTH       = gray_pkg::DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_master,
  input  logic             rstb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk_master) begin
    if (!rstb) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_count_sampler.sv
// Samples the synchronised Gray count and emits per-sample binary deltas over valid/ready.
//   state      | meaning
//   SLOT_EMPTY | no pending result, out_valid low
//   SLOT_FULL  | out_delta holds a result awaiting out_ready
module gray_count_sampler
  import gray_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk_master,
  input  logic                        rstb,
  input  logic [WIDTH-1:0]            gray_in,
  input  logic                        sample,
  input  logic                        ovr_clr,
  output logic                        overrun,
  gray_count_sampler_if.master        out_if
);

  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] gray_sync_q;
  logic [WIDTH-1:0] cur_bin;
  logic [WIDTH-1:0] last_bin;
  logic [WIDTH-1:0] delta;
  logic [WIDTH-1:0] out_delta_q;
  logic             load;
  logic             drop;

  gray_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_master (clk_master),
    .rstb       (rstb),
    .d          (gray_in),
    .q          (gray_sync_q)
  );

  assign cur_bin = WIDTH'(gray2bin(GRAY_MAX_W'(gray_sync_q)));
  assign delta   = cur_bin - last_bin;

  always_ff @(posedge clk_master) begin
    if (!rstb) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      SLOT_EMPTY: begin
        if (sample) begin
          load    = 1'b1;
          state_d = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (sample && out_if.out_ready) begin
          load = 1'b1;
        end else if (sample) begin
          drop = 1'b1;
        end else if (out_if.out_ready) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  // A dropped sample leaves last_bin alone so its events fold into the next delta.
  always_ff @(posedge clk_master) begin
    if (!rstb) begin
      last_bin    <= '0;
      out_delta_q <= '0;
    end else if (load) begin
      last_bin    <= cur_bin;
      out_delta_q <= delta;
    end
  end

  always_ff @(posedge clk_master) begin
    if (!rstb) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

  assign out_if.out_delta = out_delta_q;
  assign out_if.out_valid = (state_q == SLOT_FULL);

endmodule

// File: tb/tb_gray_count_sampler.sv
// Directed bench for gray_count_sampler with a per-cycle reference model of the sample/delta rules.
module tb_gray_count_sampler;
  import gray_pkg::*;

  localparam int W = 4;

  logic         clk_master = 1'b0;
  logic         rstb;
  logic [W-1:0] gray_in;
  logic         sample;
  logic         ovr_clr;
  logic         overrun;

  gray_count_sampler_if #(.WIDTH(W)) sif ();

  gray_count_sampler #(
    .WIDTH       (W),
    .SYNC_STAGES (2)
  ) dut (
    .clk_master (clk_master),
    .rstb       (rstb),
    .gray_in    (gray_in),
    .sample     (sample),
    .ovr_clr    (ovr_clr),
    .overrun    (overrun),
    .out_if     (sif.master)
  );

  always #5 clk_master = ~clk_master;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;
  int cnt = 0;

  // Reference: count seen by the sampler is the input word from two edges ago.
  int           hist [2];
  logic [W-1:0] m_delta;
  logic [W-1:0] m_last;
  bit           m_valid;
  bit           m_ovr;

  function automatic int decode(input logic [W-1:0] g);
    int v = 0;
    for (int i = 0; i < W; i++) v = v ^ (int'(g) >> i);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_master) begin
    if (!rstb) begin
      m_delta = '0; m_last = '0; m_valid = 1'b0; m_ovr = 1'b0;
      hist[0] = 0; hist[1] = 0;
    end else begin
      automatic bit slot_free = !m_valid || sif.out_ready;
      automatic logic [W-1:0] cur = W'(hist[1]);
      if (sample && !slot_free) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
      if (sample && slot_free) begin
        m_delta = cur - m_last;
        m_last  = cur;
        m_valid = 1'b1;
      end else if (sif.out_ready) begin
        m_valid = 1'b0;
      end
      hist[1] = hist[0];
      hist[0] = decode(gray_in);
    end
  end

  always @(negedge clk_master) begin
    if (checking) begin
      check("model_valid",   int'(sif.out_valid), int'(m_valid));
      check("model_overrun", int'(overrun),       int'(m_ovr));
      check("model_delta",   int'(sif.out_delta), int'(m_delta));
    end
  end

  task automatic tick();
    @(negedge clk_master);
  endtask

  task automatic pulse_sample();
    sample = 1'b1;
    tick();
    sample = 1'b0;
  endtask

  task automatic step_to(input int n);
    while (cnt != n) begin
      cnt = (cnt + 1) % (1 << W);
      gray_in = W'(bin2gray(32'(cnt)));
      tick();
    end
  endtask

  task automatic consume();
    sif.out_ready = 1'b1;
    tick();
    sif.out_ready = 1'b0;
  endtask

  initial begin
    rstb = 1'b0; gray_in = '0; sample = 1'b0; ovr_clr = 1'b0; sif.out_ready = 1'b0;
    repeat (3) tick();
    checking = 1'b1;
    rstb = 1'b1;
    tick();
    check("reset_valid", int'(sif.out_valid), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_delta", int'(sif.out_delta), 0);

    // first sample after reset
    gray_in = 4'b0111; cnt = 5;
    repeat (3) tick();
    pulse_sample();
    check("first_valid", int'(sif.out_valid), 1);
    check("first_delta", int'(sif.out_delta), 5);
    check("first_model", int'(m_delta), 5);

    // second sample with ready held high
    sif.out_ready = 1'b1;
    gray_in = 4'b1010; cnt = 12;
    repeat (3) tick();
    sample = 1'b1;
    tick();
    sample = 1'b0; sif.out_ready = 1'b0;
    check("second_valid", int'(sif.out_valid), 1);
    check("second_delta", int'(sif.out_delta), 7);

    // wrap-around 12 -> 2
    consume();
    step_to(2);
    check("wrap_gray_word", int'(gray_in), 4'b0011);
    repeat (3) tick();
    pulse_sample();
    check("wrap_delta", int'(sif.out_delta), 6);
    check("wrap_model", int'(m_delta), 6);

    // overrun: FULL with 5, three more events, sample dropped
    consume();
    step_to(7);
    repeat (3) tick();
    pulse_sample();
    check("pre_ovr_delta", int'(sif.out_delta), 5);
    step_to(10);
    repeat (3) tick();
    pulse_sample();
    check("ovr_flag", int'(overrun), 1);
    check("ovr_delta_held", int'(sif.out_delta), 5);
    check("ovr_valid_held", int'(sif.out_valid), 1);
    consume();
    check("after_handshake_valid", int'(sif.out_valid), 0);
    step_to(11);
    repeat (3) tick();
    pulse_sample();
    check("folded_delta", int'(sif.out_delta), 4);
    check("folded_model", int'(m_delta), 4);
    check("ovr_sticky", int'(overrun), 1);

    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_cleared", int'(overrun), 0);

    // simultaneous handshake and sample
    step_to(13);
    repeat (3) tick();
    sample = 1'b1; sif.out_ready = 1'b1;
    tick();
    sample = 1'b0; sif.out_ready = 1'b0;
    check("simul_valid", int'(sif.out_valid), 1);
    check("simul_delta", int'(sif.out_delta), 2);
    check("simul_no_ovr", int'(overrun), 0);

    // drop and clear in the same cycle: set wins
    step_to(14);
    repeat (3) tick();
    sample = 1'b1; ovr_clr = 1'b1;
    tick();
    sample = 1'b0; ovr_clr = 1'b0;
    check("set_wins", int'(overrun), 1);
    check("set_wins_delta", int'(sif.out_delta), 2);

    // reset mid-operation, sample during reset ignored
    rstb = 1'b0; sample = 1'b1; gray_in = '0; cnt = 0;
    tick();
    check("midrst_valid", int'(sif.out_valid), 0);
    check("midrst_overrun", int'(overrun), 0);
    check("midrst_delta", int'(sif.out_delta), 0);
    sample = 1'b0;
    tick();
    rstb = 1'b1;
    step_to(2);
    repeat (3) tick();
    pulse_sample();
    check("post_rst_delta", int'(sif.out_delta), 2);

    // back-to-back samples with ready held high
    sif.out_ready = 1'b1;
    step_to(3);
    repeat (3) tick();
    sample = 1'b1;
    tick();
    check("b2b_first", int'(sif.out_delta), 1);
    step_to(5);
    sample = 1'b0;
    repeat (3) tick();
    sif.out_ready = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
